mul_share_arb: RTL
==================

MUL_SHARE_ARB -- requirements
Module: mul_share_arb

Interface
REQ-001 The block SHALL have one parameter: NREQ, default 4, number of requesters sharing the multiplier; it is fixed at 4 for this release.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port req_valid, input, 4 bits: bit i means requester i presents operands.
REQ-006 Port req_a, input, 32 bits: requester i multiplicand on bits [8i+7:8i], unsigned.
REQ-007 Port req_b, input, 32 bits: requester i multiplier on bits [8i+7:8i], unsigned.
REQ-008 Port req_ready, output, 4 bits: one-hot or zero; bit i high means requester i is accepted this cycle.
REQ-009 Port rsp_valid, output, 1 bit: a result is presented.
REQ-010 Port rsp_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-011 Port rsp_data, output, 16 bits: the unsigned product a*b.
REQ-012 Port rsp_id, output, 2 bits: index of the requester that issued the result.
REQ-013 Port busy, output, 1 bit: high when any pipeline stage holds a valid entry.

Function
REQ-014 A request from requester i SHALL transfer when req_valid[i] and req_ready[i] are both high in the same cycle.
REQ-015 A result SHALL transfer when rsp_valid and rsp_ready are both high in the same cycle.
REQ-016 The pipeline SHALL have two register stages:
- S1 holds a, b, id and a valid flag.
- The multiplier sits combinationally between S1 and S2.
- S2 holds the 16-bit product, id and a valid flag.
REQ-017 rsp_valid, rsp_data and rsp_id SHALL be driven directly from S2.
REQ-018 A request accepted in cycle N SHALL appear on rsp_valid in cycle N+2 when there is no backpressure.
REQ-019 S2 SHALL load from S1 when S2 is empty or S2 transfers in the same cycle; otherwise S2 and S1 SHALL hold.
REQ-020 S1 SHALL accept a new grant when it is empty or S1 advances to S2 in the same cycle.
REQ-021 req_ready SHALL be all zero when S1 cannot accept.
REQ-022 Sustained throughput SHALL be one product per cycle while rsp_ready stays high.
REQ-023 Arbitration SHALL be round-robin:
- the search starts at (last_grant+1) mod 4;
- the first requester found with req_valid high is granted;
- last_grant SHALL update only when a transfer occurs.
REQ-024 req_ready SHALL be combinational from req_valid, last_grant and stall state, with at most one bit set.
REQ-025 A requester that deasserts req_valid before it is granted SHALL lose its place without side effects.
REQ-026 Any requester held valid continuously SHALL be granted within 4 grant opportunities.
REQ-027 rsp_data SHALL equal the full 16-bit unsigned product with no truncation; 255*255 gives 65025.
REQ-028 When S2 transfers and S1 is empty in the same cycle, S2 SHALL become empty.
REQ-029 When an S2 transfer, an S1 advance and a new grant all occur in one cycle, the pipeline SHALL remain full with no loss or duplication.
REQ-030 While rsp_valid is high and rsp_ready is low, rsp_data and rsp_id SHALL remain stable.

Reset
REQ-031 Reset SHALL clear both stage valid flags, so that rsp_valid=0, busy=0 and req_ready=0 in the cycle after reset is applied.
REQ-032 Reset SHALL set last_grant to 3, so that requester 0 has highest priority first.
REQ-033 Reset SHALL set rsp_data=0 and rsp_id=0.
REQ-034 Reset asserted mid-operation SHALL discard in-flight entries; no result for them SHALL ever appear.
REQ-035 req_ready SHALL be 0 in every cycle that rst is high.

Structure
REQ-036 NREQ, the operand width (8), the product width (16) and the id width (2) SHALL be constants in the shared package mul_pkg.
REQ-037 One sub-module SHALL be instantiated: the team's existing 8x8 Wallace multiplier, wallace, fed from the S1 operands.
REQ-038 The arbiter SHALL be written inline; no further sub-modules.

Verification
REQ-039 Single request: req_valid=0001, a0=255, b0=255 in cycle N -> rsp_valid in N+2, rsp_data=65025, rsp_id=0.
REQ-040 Contention: req_valid=1111 held, a_i=i+1, b_i=10 -> grants in order 0,1,2,3,0...; rsp_data sequence 10,20,30,40; one result per cycle.
REQ-041 Fairness: requesters 0 and 2 held valid -> grants alternate 0,2,0,2; requesters 1 and 3 never granted.
REQ-042 Backpressure: rsp_ready=0 for 3 cycles with requests pending -> rsp_data held stable, req_ready=0000 once S1 is full; after release, products arrive in order with none lost.
REQ-043 Reset mid-flight: rst pulsed one cycle while S1 and S2 are full -> rsp_valid=0 and busy=0 next cycle; no stale result ever appears; requester 0 is granted first.
REQ-044 Zero operands: a=0, b=200 and a=1, b=0 -> rsp_data=0 for both, with correct rsp_id.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared constants and types for the shared-multiplier arbiter.
//   NREQ   : number of requesters sharing one multiplier
//   OP_W   : unsigned operand width
//   PROD_W : full product width (no truncation)
//   ID_W   : requester index width
package mul_pkg;

    localparam int NREQ   = 4;
    localparam int OP_W   = 8;
    localparam int PROD_W = 16;
    localparam int ID_W   = 2;

    typedef logic [OP_W-1:0]   op_t;
    typedef logic [PROD_W-1:0] prod_t;
    typedef logic [ID_W-1:0]   id_t;

endpackage

// File: rtl/mul_share_arb_wallace.sv
// wallace: combinational 8x8 unsigned multiplier built as a carry-save
// (Wallace) reduction of the partial products, followed by one final adder.
// Ports:
//   a, b : unsigned operands
//   p    : full 16-bit product
module wallace
    import mul_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] p
);

    // 3:2 compressor across a whole row: {carry<<1, sum}
    function automatic logic [2*PROD_W-1:0] csa(input prod_t x, input prod_t y, input prod_t z);
        prod_t s;
        prod_t c;
        s = x ^ y ^ z;
        c = ((x & y) | (x & z) | (y & z)) << 1;
        return {c, s};
    endfunction

    prod_t                 pp [OP_W];
    logic [2*PROD_W-1:0]   r1a, r1b, r2a, r2b, r3, r4;

    // Carry bits shifted past bit 15 are dropped; the arithmetic stays exact
    // modulo 2^16 and the product never exceeds 16 bits.
    always_comb begin
        for (int i = 0; i < OP_W; i++) begin
            pp[i] = b[i] ? (prod_t'(a) << i) : '0;
        end
        r1a = csa(pp[0], pp[1], pp[2]);
        r1b = csa(pp[3], pp[4], pp[5]);
        r2a = csa(r1a[PROD_W-1:0], r1a[2*PROD_W-1:PROD_W], r1b[PROD_W-1:0]);
        r2b = csa(r1b[2*PROD_W-1:PROD_W], pp[6], pp[7]);
        r3  = csa(r2a[PROD_W-1:0], r2a[2*PROD_W-1:PROD_W], r2b[PROD_W-1:0]);
        r4  = csa(r3[PROD_W-1:0], r3[2*PROD_W-1:PROD_W], r2b[2*PROD_W-1:PROD_W]);
        p   = r4[PROD_W-1:0] + r4[2*PROD_W-1:PROD_W];
    end

endmodule

// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin arbiter sharing one 8x8 multiplier between
// NREQ requesters through a two-stage valid/ready pipeline.
//   S1 holds the granted operands and id; the multiplier sits between S1
//   and S2; S2 holds the product and id and drives the response directly.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake (req_ready one-hot or zero)
//   req_a, req_b        : packed 8-bit operands, requester i on [8i+7:8i]
//   rsp_valid/rsp_ready : result handshake
//   rsp_data, rsp_id    : 16-bit product and issuing requester index
//   busy                : any stage holds a valid entry
module mul_share_arb #(
    parameter int NREQ = mul_pkg::NREQ
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NREQ-1:0]                  req_valid,
    input  logic [NREQ*mul_pkg::OP_W-1:0]    req_a,
    input  logic [NREQ*mul_pkg::OP_W-1:0]    req_b,
    output logic [NREQ-1:0]                  req_ready,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [mul_pkg::PROD_W-1:0]       rsp_data,
    output logic [mul_pkg::ID_W-1:0]         rsp_id,
    output logic                             busy
);

    localparam int OP_W = mul_pkg::OP_W;

    logic            s1_valid;
    mul_pkg::op_t    s1_a, s1_b;
    mul_pkg::id_t    s1_id;
    logic            s2_valid;
    mul_pkg::prod_t  s2_data;
    mul_pkg::id_t    s2_id;
    mul_pkg::id_t    last_grant;
    mul_pkg::prod_t  product;

    logic            s2_load;
    logic            s1_accept;
    logic            grant_found;
    logic            grant_take;
    mul_pkg::id_t    grant_id;
    mul_pkg::id_t    cand;

    // S2 may take S1's contents when it is empty or draining this cycle;
    // S1 may take a new grant when empty or moving into S2.
    assign s2_load   = !s2_valid || rsp_ready;
    assign s1_accept = !s1_valid || s2_load;

    // Search order last_grant+1 .. last_grant+NREQ; the 2-bit wrap does the mod.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = last_grant;
        cand        = last_grant;
        for (int k = 1; k <= NREQ; k++) begin
            cand = last_grant + mul_pkg::id_t'(k);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && s1_accept && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign grant_take = |req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_id      <= '0;
            last_grant <= mul_pkg::id_t'(NREQ - 1);
        end else if (s1_accept) begin
            s1_valid <= grant_take;
            if (grant_take) begin
                s1_a       <= req_a[grant_id*OP_W +: OP_W];
                s1_b       <= req_b[grant_id*OP_W +: OP_W];
                s1_id      <= grant_id;
                last_grant <= grant_id;
            end
        end
    end

    wallace u_mul (
        .a (s1_a),
        .b (s1_b),
        .p (product)
    );

    // When S1 is empty the old product/id are kept but marked invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_id    <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= product;
                s2_id   <= s1_id;
            end
        end
    end

    assign rsp_valid = s2_valid;
    assign rsp_data  = s2_data;
    assign rsp_id    = s2_id;
    assign busy      = s1_valid || s2_valid;

endmodule
